// File: rtl/banked_scratchpad_ctrl_if.sv
// Request/response bundle for banked_scratchpad_ctrl. The master drives the
// read/write request fields, and the slave (the scratchpad) returns the data.

// Handshake: a read is taken on a rising edge where out_ready and in_re are
// both high, and a write on one where out_ready and in_we are both high. There
// is no back-pressure once out_ready is high. out_rvalid is a one-cycle pulse,
// raised on the edge after each accepted read. out_data holds its value
// between pulses.
interface banked_scratchpad_ctrl_if #(
  parameter int DATA_W    = 128,
  parameter int ADDR_BITS = 4
);
  logic                    in_re;
  logic [ADDR_BITS-1:0]    in_raddr;
  logic                    in_we;
  logic [ADDR_BITS-1:0]    in_waddr;
  logic [DATA_W/8-1:0]     in_wstrb;
  logic [DATA_W-1:0]       in_data;
  logic [DATA_W-1:0]       out_data;
  logic                    out_rvalid;
  logic                    out_ready;

  modport master (
    output in_re, in_raddr, in_we, in_waddr, in_wstrb, in_data,
    input  out_data, out_rvalid, out_ready
  );

  modport slave (
    input  in_re, in_raddr, in_we, in_waddr, in_wstrb, in_data,
    output out_data, out_rvalid, out_ready
  );
endinterface

// File: rtl/banked_scratchpad_ctrl.sv
// Scratchpad with a registered read port, byte-strobed writes and a zero-fill INIT sequencer after reset.
// Define SPAD_WR_BYPASS_EN to forward a same-cycle, same-address write into the read result.
module banked_scratchpad_ctrl #(
  parameter int DATA_W    = 128,
  parameter int ADDR_BITS = 4,
  parameter int DEPTH     = 16
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  banked_scratchpad_ctrl_if.slave  bus,
  output logic                     dbg_state
);

  localparam int                   STRB_W  = DATA_W / 8;
  localparam logic [ADDR_BITS:0]   DEPTH_C = (ADDR_BITS + 1)'(DEPTH);
  localparam logic [ADDR_BITS:0]   ONE_C   = (ADDR_BITS + 1)'(1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [ADDR_BITS:0]     clr_addr_q;
  logic [ADDR_BITS:0]     clr_addr_d;
  logic                   clr_we;

  logic [DATA_W-1:0]      mem [0:DEPTH-1];

  logic                   run;
  logic                   rd_in_range;
  logic                   wr_in_range;
  logic                   rd_accept;
  logic                   wr_accept;
  logic [DATA_W-1:0]      rd_old;
  logic [DATA_W-1:0]      rd_word;
  logic [DATA_W-1:0]      wr_word;
  logic [DATA_W-1:0]      rdata_q;
  logic                   rvalid_q;

  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
    end
    return res;
  endfunction

  // clr_addr counts one past the last entry, so the hand-over to RUN takes
  // its own edge after entry DEPTH-1 is cleared.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_we     = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clr_addr_q == DEPTH_C) begin
          state_d = ST_RUN;
        end else begin
          clr_we     = 1'b1;
          clr_addr_d = clr_addr_q + ONE_C;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q    <= ST_INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign run         = (state_q == ST_RUN);
  assign rd_in_range = ({1'b0, bus.in_raddr} < DEPTH_C);
  assign wr_in_range = ({1'b0, bus.in_waddr} < DEPTH_C);
  assign rd_accept   = run && bus.in_re;
  assign wr_accept   = run && bus.in_we && wr_in_range;

  // Out-of-range reads still complete, but they return zero.
  assign rd_old  = rd_in_range ? mem[bus.in_raddr] : '0;
  assign wr_word = merge_bytes(mem[bus.in_waddr], bus.in_data, bus.in_wstrb);

  always_comb begin
    rd_word = rd_old;
`ifdef SPAD_WR_BYPASS_EN
    if (wr_accept && (bus.in_waddr == bus.in_raddr)) begin
      rd_word = wr_word;
    end
`endif
  end

  // Storage is not reset directly; the INIT sweep zeroes it instead.
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      if (clr_we) begin
        mem[clr_addr_q[ADDR_BITS-1:0]] <= '0;
      end
      if (wr_accept) begin
        mem[bus.in_waddr] <= wr_word;
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_accept;
      if (rd_accept) begin
        rdata_q <= rd_word;
      end
    end
  end

  assign bus.out_data   = rdata_q;
  assign bus.out_rvalid = rvalid_q;
  assign bus.out_ready  = run;
  assign dbg_state      = run;

endmodule
